// File: rtl/pe_8x8_feeder.sv
// pe_8x8_feeder -- input skew stage for pe_8x8_cluster.
//
// Buffers one tile (K beats; each beat is one column of A and one row of B,
// eight 16-bit lanes each). It then replays the tile with a diagonal skew:
// lane i is delayed by i cycles. After the last skew slot it holds array_en
// through a flush window and pulses tile_done on the final flush cycle.
//
// Optional feature: define PE_FEEDER_PINGPONG_EN to get two buffer banks.
// One bank fills while the other is issued/flushed. A full waiting bank
// issues back-to-back right after tile_done.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     beat offered
//   in_ready     feeder can accept a beat (registered)
//   in_act       column k of A, lane i at [16i+15:16i]
//   in_wgt       row k of B, lane j at [16j+15:16j]
//   in_len       K for the tile, sampled on its first beat (0 or >DEPTH -> DEPTH)
//   activations  skewed A lanes to the array
//   weights      skewed B lanes to the array
//   done         per-row last-element flag
//   array_en     array enable (ISSUE and FLUSH)
//   busy         high in ISSUE or FLUSH
//   tile_done    one-cycle pulse on the last FLUSH cycle
module pe_8x8_feeder #(
  parameter int DEPTH        = 8,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_act,
  input  logic [127:0] in_wgt,
  input  logic [3:0]   in_len,
  output logic [127:0] activations,
  output logic [127:0] weights,
  output logic [7:0]   done,
  output logic         array_en,
  output logic         busy,
  output logic         tile_done
);
  localparam int DATA_W = 16;
  localparam int LANES  = 8;
  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOT_W = $clog2(DEPTH + 8);
  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
`ifdef PE_FEEDER_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif

  typedef enum logic [1:0] {LOAD, ISSUE, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          full_q, full_d;
  logic [LEN_W-1:0]    len_q [2];
  logic [LEN_W-1:0]    len_d [2];

  logic [127:0]        act_q, act_d;
  logic [127:0]        wgt_q, wgt_d;
  logic [7:0]          done_q, done_d;
  logic                en_q, en_d;
  logic                tile_done_q, tile_done_d;
  logic                in_ready_q, in_ready_d;

  // Tile storage; data only, never reset.
  logic [127:0]        buf_a_q [2][DEPTH];
  logic [127:0]        buf_b_q [2][DEPTH];
  logic [127:0]        act_eff [DEPTH];
  logic [127:0]        wgt_eff [DEPTH];

  logic                wr_en;
  logic [LEN_W-1:0]    len_in;
  logic [LEN_W-1:0]    cur_len;
  logic                last_beat;

  assign wr_en     = in_valid && in_ready_q;
  assign len_in    = (in_len == 4'd0 || int'(in_len) > DEPTH) ? LEN_W'(DEPTH) : LEN_W'(in_len);
  assign cur_len   = (wr_ptr_q == '0) ? len_in : len_q[wr_bank_q];
  assign last_beat = wr_en && (wr_ptr_q == PTR_W'(cur_len - 1'b1));

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    fcnt_d    = fcnt_q;
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    len_d     = len_q;

    if (wr_en) begin
      if (wr_ptr_q == '0) len_d[wr_bank_q] = len_in;
      if (last_beat) begin
        wr_ptr_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        if (PINGPONG) wr_bank_d = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // state_q/slot_q/fcnt_q describe what the outputs show this cycle.
    case (state_q)
      LOAD: begin
        if (last_beat) begin
          state_d   = ISSUE;
          slot_d    = '0;
          rd_bank_d = wr_bank_q;
        end
      end
      ISSUE: begin
        if (slot_q == SLOT_W'(len_q[rd_bank_q]) + SLOT_W'(6)) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_q == FCNT_W'(FLUSH_CYCLES - 1)) begin
          full_d[rd_bank_q] = 1'b0;
          // A bank completed on this very cycle also counts as full.
          if (PINGPONG && full_d[~rd_bank_q]) begin
            state_d   = ISSUE;
            slot_d    = '0;
            rd_bank_d = ~rd_bank_q;
          end else begin
            state_d = LOAD;
          end
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Bypass the beat being written this cycle so a slot that needs it
  // (len = 1, or a bank completing on the tile_done cycle) sees it.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      act_eff[k] = buf_a_q[rd_bank_d][k];
      wgt_eff[k] = buf_b_q[rd_bank_d][k];
      if (wr_en && wr_bank_q == rd_bank_d && wr_ptr_q == PTR_W'(k)) begin
        act_eff[k] = in_act;
        wgt_eff[k] = in_wgt;
      end
    end
  end

  always_comb begin
    act_d  = '0;
    wgt_d  = '0;
    done_d = '0;
    if (state_d == ISSUE) begin
      for (int i = 0; i < LANES; i++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (int'(slot_d) - i == k && k < int'(len_d[rd_bank_d])) begin
            act_d[i*DATA_W +: DATA_W] = act_eff[k][i*DATA_W +: DATA_W];
            wgt_d[i*DATA_W +: DATA_W] = wgt_eff[k][i*DATA_W +: DATA_W];
          end
        end
        done_d[i] = (int'(slot_d) == int'(len_d[rd_bank_d]) - 1 + i);
      end
    end
    en_d        = (state_d != LOAD);
    tile_done_d = (state_d == FLUSH) && (fcnt_d == FCNT_W'(FLUSH_CYCLES - 1));
    if (PINGPONG) in_ready_d = !((state_d != LOAD) && full_d[wr_bank_d]);
    else          in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      slot_q      <= '0;
      fcnt_q      <= '0;
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      act_q       <= '0;
      wgt_q       <= '0;
      done_q      <= '0;
      en_q        <= 1'b0;
      tile_done_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      fcnt_q      <= fcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      len_q[0]    <= len_d[0];
      len_q[1]    <= len_d[1];
      act_q       <= act_d;
      wgt_q       <= wgt_d;
      done_q      <= done_d;
      en_q        <= en_d;
      tile_done_q <= tile_done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_ptr_q == PTR_W'(k)) begin
          buf_a_q[wr_bank_q][k] <= in_act;
          buf_b_q[wr_bank_q][k] <= in_wgt;
        end
      end
    end
  end

  assign activations = act_q;
  assign weights     = wgt_q;
  assign done        = done_q;
  assign array_en    = en_q;
  assign busy        = en_q;
  assign tile_done   = tile_done_q;
  assign in_ready    = in_ready_q;

endmodule

// File: tb/tb_pe_8x8_feeder.sv
// Directed bench for pe_8x8_feeder: a table of tiles checked slot by slot
// against a skew model, plus hand sequences for the explicit basic-skew
// values, reset mid-ISSUE, and backpressure (or ping-pong when
// PE_FEEDER_PINGPONG_EN is defined).
module tb_pe_8x8_feeder;
  localparam int FC = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_act;
  logic [127:0] in_wgt;
  logic [3:0]   in_len;
  logic [127:0] activations;
  logic [127:0] weights;
  logic [7:0]   done;
  logic         array_en;
  logic         busy;
  logic         tile_done;

  int n_vec  = 0;
  int n_fail = 0;

  pe_8x8_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_act      (in_act),
    .in_wgt      (in_wgt),
    .in_len      (in_len),
    .activations (activations),
    .weights     (weights),
    .done        (done),
    .array_en    (array_en),
    .busy        (busy),
    .tile_done   (tile_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  in_len;
    int          eff_len;
    logic [15:0] base;
    bit          gaps;
  } tile_vec_t;

  function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  // Beat k, lane i: A = {k,i} ^ base, B = {i,k} ^ base.
  function automatic logic [127:0] mk_act(logic [15:0] base, int k);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = {8'(k), 8'(i)} ^ base;
    return r;
  endfunction

  function automatic logic [127:0] mk_wgt(logic [15:0] base, int k);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = {8'(i), 8'(k)} ^ base;
    return r;
  endfunction

  function automatic logic [127:0] exp_act(logic [15:0] base, int len, int t);
    logic [127:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if (t - i >= 0 && t - i < len) r[i*16 +: 16] = {8'(t - i), 8'(i)} ^ base;
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_wgt(logic [15:0] base, int len, int t);
    logic [127:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if (t - i >= 0 && t - i < len) r[i*16 +: 16] = {8'(i), 8'(t - i)} ^ base;
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_done(int len, int t);
    logic [127:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = (t == len - 1 + i);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where slot 0 is visible.
  task automatic send_tile(int nb, logic [3:0] l, logic [15:0] base, bit gaps);
    int k = 0;
    int guard = 0;
    while (k < nb) begin
      if (guard >= 100) begin
        chk("send_timeout", 128'(k), 128'(nb));
        break;
      end
      if (gaps && (guard % 3 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_len   = l;
        in_act   = mk_act(base, k);
        in_wgt   = mk_wgt(base, k);
        if (in_ready) k++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
  endtask

  // Entered at the slot-0 negedge; walks ISSUE and FLUSH.
  task automatic check_tile(int len, logic [15:0] base, bit hold, bit b2b);
    for (int t = 0; t < len + 7; t++) begin
      if (hold) begin
        in_valid = 1'b1;
        in_len   = 4'd2;
        in_act   = {8{16'hDEAD}};
        in_wgt   = {8{16'hBEEF}};
      end
      chk($sformatf("act L=%0d t=%0d", len, t), activations, exp_act(base, len, t));
      chk($sformatf("wgt L=%0d t=%0d", len, t), weights, exp_wgt(base, len, t));
      chk($sformatf("done L=%0d t=%0d", len, t), 128'(done), exp_done(len, t));
`ifdef PE_FEEDER_PINGPONG_EN
      chk($sformatf("issue_ctl t=%0d", t), {array_en, busy, tile_done}, 128'b110);
`else
      chk($sformatf("issue_ctl t=%0d", t), {array_en, busy, tile_done, in_ready}, 128'b1100);
`endif
      @(negedge clk);
    end
    for (int f = 0; f < FC; f++) begin
      chk($sformatf("flush_data f=%0d", f), activations | weights, 128'h0);
      chk($sformatf("flush_ctl f=%0d", f), {done, array_en, busy, tile_done},
          {8'h00, 1'b1, 1'b1, f == FC - 1});
      @(negedge clk);
    end
    if (!b2b) chk("idle_ctl", {array_en, busy, tile_done, in_ready}, 128'b0001);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_vec_t tv [6];
    tv[0] = '{4'd8,  8, 16'h0000, 1'b0};
    tv[1] = '{4'd3,  3, 16'h1000, 1'b1};
    tv[2] = '{4'd0,  8, 16'hA000, 1'b0};
    tv[3] = '{4'd12, 8, 16'h5000, 1'b1};
    tv[4] = '{4'd1,  1, 16'h2200, 1'b0};
    tv[5] = '{4'd5,  5, 16'h3300, 1'b1};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_len   = '0;
    in_act   = '0;
    in_wgt   = '0;
    repeat (3) @(negedge clk);
    chk("rst_act", activations | weights, 128'h0);
    chk("rst_ctl", {done, array_en, busy, tile_done, in_ready}, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 128'(in_ready), 128'h1);

    // Basic skew with explicit spot values.
    send_tile(8, 4'd8, 16'h0000, 1'b0);
    chk("basic_s0_act", activations, 128'h0);
    chk("basic_s0_en", 128'(array_en), 128'h1);
    repeat (7) @(negedge clk);
    chk("basic_s7_lane7", 128'(activations[127:112]), 128'h0007);
    chk("basic_s7_done", 128'(done), 128'h01);
    repeat (7) @(negedge clk);
    chk("basic_s14_lane7", 128'(activations[127:112]), 128'h0707);
    chk("basic_s14_done", 128'(done), 128'h80);
    repeat (7) @(negedge clk);
    chk("basic_pre_tile_done", 128'(tile_done), 128'h0);
    @(negedge clk);
    chk("basic_tile_done", 128'(tile_done), 128'h1);
    @(negedge clk);
    chk("basic_en_fall", {array_en, tile_done, in_ready}, 128'b001);

    for (int v = 0; v < 6; v++) begin
      send_tile(tv[v].eff_len, tv[v].in_len, tv[v].base, tv[v].gaps);
      check_tile(tv[v].eff_len, tv[v].base, 1'b0, 1'b0);
    end

    // Reset at slot 5 of ISSUE.
    send_tile(8, 4'd8, 16'h3000, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_s5_act", activations, exp_act(16'h3000, 8, 5));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", activations | weights, 128'h0);
    chk("mid_rst_ctl", {done, array_en, busy, tile_done, in_ready}, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {array_en, busy, tile_done, in_ready}, 128'b0001);
    for (int c = 0; c < 20; c++) begin
      chk("mid_rst_quiet", {array_en, tile_done, done}, 128'h0);
      @(negedge clk);
    end
    send_tile(8, 4'd8, 16'h0000, 1'b0);
    check_tile(8, 16'h0000, 1'b0, 1'b0);

`ifdef PE_FEEDER_PINGPONG_EN
    send_tile(8, 4'd8, 16'h6000, 1'b0);
    fork
      check_tile(8, 16'h6000, 1'b0, 1'b1);
      send_tile(5, 4'd5, 16'h7000, 1'b1);
    join
    check_tile(5, 16'h7000, 1'b0, 1'b0);
`else
    // in_valid held with junk during ISSUE/FLUSH; next tile's first beat
    // goes in the cycle after tile_done.
    send_tile(4, 4'd4, 16'h4400, 1'b0);
    check_tile(4, 16'h4400, 1'b1, 1'b0);
    send_tile(4, 4'd4, 16'h4500, 1'b0);
    check_tile(4, 16'h4500, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
